serial_mag_cmp_ctrl: RTL and testbench

//  Sequencer that performs a WIDTH-bit unsigned magnitude compare by stepping one

---
 rtl/serial_cmp_pkg.sv | 34 +++
 rtl/serial_mag_cmp_ctrl_if.sv | 34 +++
 rtl/cmp1_slice.sv | 21 ++
 rtl/serial_mag_cmp_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_mag_cmp_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared types for the serial magnitude comparator
//
// Purpose: FSM state encoding, sticky decision encoding and the helper that
// turns a 1-bit slice result into a decision code.
// Ports: none (package).
package serial_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Sticky decision: UND until the first differing bit, MSB-first.
   typedef enum logic [1:0] {
      UND = 2'd0,
      LT  = 2'd1,
      GT  = 2'd2
   } dec_t;

   // A slice reporting anything other than a clean one-hot lt or gt is
   // treated as "no decision on this bit".
   function automatic dec_t slice_dec(input logic s_lt, input logic s_gt, input logic s_eq);
      dec_t d;
      d = UND;
      if (s_lt && !s_gt && !s_eq) begin
         d = LT;
      end else if (s_gt && !s_lt && !s_eq) begin
         d = GT;
      end
      return d;
   endfunction

endpackage

// File: rtl/serial_mag_cmp_ctrl_if.sv
// rtl/serial_mag_cmp_ctrl_if.sv - requester-side handshake bundle
//
// Purpose: groups the start/done handshake, operands and result flags.
// Signals:
//   start        request, sampled by the controller in IDLE or DONE
//   a, b         WIDTH-bit operands, captured on the accepting edge
//   busy         high while the compare is running
//   done         one-cycle pulse, result valid on that cycle
//   lt, gt, eq   result flags, held until the next result
// Modports: master (requester), slave (controller).
interface serial_mag_cmp_ctrl_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             lt;
   logic             gt;
   logic             eq;

   modport master (
      output start, a, b,
      input  busy, done, lt, gt, eq
   );

   modport slave (
      input  start, a, b,
      output busy, done, lt, gt, eq
   );

endinterface

// File: rtl/cmp1_slice.sv
// rtl/cmp1_slice.sv - combinational 1-bit magnitude comparator slice
//
// Purpose: compares two single bits; exactly one output is high.
// Ports:
//   a, b   in   operand bits
//   lt     out  a < b
//   gt     out  a > b
//   eq     out  a == b
module cmp1_slice (
   input  logic a,
   input  logic b,
   output logic lt,
   output logic gt,
   output logic eq
);

   assign lt = ~a &  b;
   assign gt =  a & ~b;
   assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// rtl/serial_mag_cmp_ctrl.sv - bit-serial unsigned magnitude compare sequencer
//
// Purpose: captures two WIDTH-bit operands on an accepted start and walks a
// single shared 1-bit comparator slice from MSB to LSB, one bit per cycle.
// The first differing bit fixes the result; later bits cannot change it.
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   bus     slave modport of serial_mag_cmp_ctrl_if (start, a, b in;
//           busy, done, lt, gt, eq out)
// Build option: SERIAL_CMP_EARLY_EXIT_EN - when defined, RUN ends on the
// first bit that decides the result instead of always stepping all bits.
module serial_mag_cmp_ctrl
   import serial_cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_mag_cmp_ctrl_if.slave bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t             state_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [CNT_W-1:0]   idx_q;
   dec_t               dec_q;
   logic               busy_q;
   logic               done_q;
   logic               lt_q;
   logic               gt_q;
   logic               eq_q;

   logic               s_lt;
   logic               s_gt;
   logic               s_eq;
   dec_t               dec_nxt;
   logic               last_bit;
   logic               finish;

   cmp1_slice u_slice (
      .a  (a_q[idx_q]),
      .b  (b_q[idx_q]),
      .lt (s_lt),
      .gt (s_gt),
      .eq (s_eq)
   );

   always_comb begin
      dec_nxt  = dec_q;
      if (dec_q == UND) begin
         dec_nxt = slice_dec(s_lt, s_gt, s_eq);
      end
      last_bit = (idx_q == '0);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      // A decided bit makes the remaining bits irrelevant.
      finish   = last_bit || (dec_nxt != UND);
`else
      finish   = last_bit;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         dec_q   <= UND;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lt_q    <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               // Accepting from DONE gives back-to-back compares with no bubble.
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  idx_q   <= CNT_W'(WIDTH - 1);
                  dec_q   <= UND;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               // start is deliberately not looked at here.
               dec_q <= dec_nxt;
               idx_q <= idx_q - CNT_W'(1);
               if (finish) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  lt_q    <= (dec_nxt == LT);
                  gt_q    <= (dec_nxt == GT);
                  eq_q    <= (dec_nxt == UND);
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.lt   = lt_q;
   assign bus.gt   = gt_q;
   assign bus.eq   = eq_q;

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// tb/tb_serial_mag_cmp_ctrl.sv - directed and scoreboard bench for serial_mag_cmp_ctrl
module tb_serial_mag_cmp_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   serial_mag_cmp_ctrl_if #(.WIDTH(8)) if8 ();
   serial_mag_cmp_ctrl_if #(.WIDTH(1)) if1 ();

   serial_mag_cmp_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
   serial_mag_cmp_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       lt;
      logic       gt;
      logic       eq;
      int         lat_fix;
      int         lat_ee;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic drive(input int w, input logic s, input logic [7:0] av, input logic [7:0] bv);
      if (w == 8) begin
         if8.start = s; if8.a = av; if8.b = bv;
      end else begin
         if1.start = s; if1.a = av[0]; if1.b = bv[0];
      end
   endtask

   task automatic sample(input int w, output logic bsy, output logic dn,
                         output logic l, output logic g, output logic e);
      if (w == 8) begin
         bsy = if8.busy; dn = if8.done; l = if8.lt; g = if8.gt; e = if8.eq;
      end else begin
         bsy = if1.busy; dn = if1.done; l = if1.lt; g = if1.gt; e = if1.eq;
      end
   endtask

   function automatic int exp_lat(input int w, input logic [7:0] av, input logic [7:0] bv);
      if (EE) begin
         for (int i = w - 1; i >= 0; i--) begin
            if (av[i] != bv[i]) return w - i + 1;
         end
      end
      return w + 1;
   endfunction

   // Issues one compare and waits (bounded) for done. lat is the number of
   // negedges after the accepting edge up to and including the done cycle.
   task automatic do_cmp(input int w, input logic [7:0] av, input logic [7:0] bv,
                         output int lat, output int busy_n,
                         output logic ol, output logic og, output logic oe);
      logic bsy, dn, l, g, e;
      drive(w, 1'b1, av, bv);
      @(posedge clk); #1;
      drive(w, 1'b0, 8'($urandom), 8'($urandom));
      lat = 0; busy_n = 0; ol = 1'b0; og = 1'b0; oe = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         sample(w, bsy, dn, l, g, e);
         if (bsy) busy_n++;
         if (dn) begin
            lat = c; ol = l; og = g; oe = e;
            break;
         end
      end
   endtask

   initial begin
      int         lat, busy_n, cnt, held_bad;
      logic       bsy, dn, l, g, e;
      logic [7:0] av, bv;
      logic [2:0] exp_r;

      vecs[0] = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 9, 9};
      vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 9, 2};
      vecs[2] = '{8'h12, 8'h13, 1'b1, 1'b0, 1'b0, 9, 9};
      vecs[3] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 9, 2};
      vecs[4] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 9, 2};
      vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 9, 9};
      vecs[6] = '{8'h3C, 8'h34, 1'b0, 1'b1, 1'b0, 9, 6};
      vecs[7] = '{8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 9, 9};

      // Reset with random inputs, including start.
      drive(8, 1'($urandom), 8'($urandom), 8'($urandom));
      drive(1, 1'($urandom), 8'($urandom), 8'($urandom));
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst8_busy", if8.busy, 0); chk("rst8_done", if8.done, 0);
      chk("rst8_lt", if8.lt, 0); chk("rst8_gt", if8.gt, 0); chk("rst8_eq", if8.eq, 0);
      chk("rst1_busy", if1.busy, 0); chk("rst1_done", if1.done, 0);
      chk("rst1_lt", if1.lt, 0); chk("rst1_gt", if1.gt, 0); chk("rst1_eq", if1.eq, 0);

      drive(8, 1'b0, 8'($urandom), 8'($urandom));
      drive(1, 1'b0, 8'($urandom), 8'($urandom));
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (if8.done || if1.done || if8.busy || if1.busy) cnt++;
      end
      chk("idle_no_done", cnt, 0);

      // Directed vector table on WIDTH=8.
      for (int i = 0; i < 8; i++) begin
         do_cmp(8, vecs[i].a, vecs[i].b, lat, busy_n, l, g, e);
         chk($sformatf("vec%0d_lt", i), l, vecs[i].lt);
         chk($sformatf("vec%0d_gt", i), g, vecs[i].gt);
         chk($sformatf("vec%0d_eq", i), e, vecs[i].eq);
         chk($sformatf("vec%0d_lat", i), lat, EE ? vecs[i].lat_ee : vecs[i].lat_fix);
         chk($sformatf("vec%0d_busy", i), busy_n, (EE ? vecs[i].lat_ee : vecs[i].lat_fix) - 1);
      end

      // Back-to-back: start on the done cycle, prior gt result held until next done.
      do_cmp(8, 8'hA5, 8'h5A, lat, busy_n, l, g, e);
      chk("b2b_first_gt", g, 1);
      drive(8, 1'b1, 8'h00, 8'hFF);
      @(posedge clk); #1;
      drive(8, 1'b0, 8'h5A, 8'h11);
      held_bad = 0; lat = 0; l = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         sample(8, bsy, dn, l, g, e);
         if (c == 1) chk("b2b_no_bubble", bsy, 1);
         if (dn) begin
            lat = c;
            break;
         end
         if (l !== 1'b0 || g !== 1'b1 || e !== 1'b0) held_bad++;
      end
      chk("b2b_held", held_bad, 0);
      chk("b2b_lat", lat, EE ? 2 : 9);
      chk("b2b_lt", l, 1);

      // start pulsed mid-RUN is ignored.
      drive(8, 1'b1, 8'h12, 8'h13);
      @(posedge clk); #1;
      drive(8, 1'b0, 8'h00, 8'h00);
      lat = 0; l = 1'b0; g = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         sample(8, bsy, dn, l, g, e);
         if (dn) begin
            lat = c;
            break;
         end
         if (c == 3) drive(8, 1'b1, 8'hFF, 8'h00);
         else if (c == 4) drive(8, 1'b0, 8'hFF, 8'h00);
      end
      chk("ignore_lat", lat, 9);
      chk("ignore_lt", l, 1);
      chk("ignore_gt", g, 0);

      // Reset mid-RUN: immediate reset values, no done afterwards.
      drive(8, 1'b1, 8'h00, 8'h00);
      @(posedge clk); #1;
      drive(8, 1'b0, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      chk("midrun_busy_before", if8.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_busy", if8.busy, 0); chk("midrun_rst_done", if8.done, 0);
      chk("midrun_rst_lt", if8.lt, 0); chk("midrun_rst_gt", if8.gt, 0);
      chk("midrun_rst_eq", if8.eq, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (if8.done || if8.busy) cnt++;
      end
      chk("midrun_no_done", cnt, 0);

      // Random scoreboard on both widths.
      for (int w = 8; w >= 1; w -= 7) begin
         for (int n = 0; n < 1000; n++) begin
            av = 8'($urandom);
            bv = (n % 8 == 0) ? av : 8'($urandom);
            if (w == 1) begin
               av = {7'd0, av[0]};
               bv = {7'd0, bv[0]};
            end
            exp_r = (av < bv) ? 3'b100 : ((av > bv) ? 3'b010 : 3'b001);
            do_cmp(w, av, bv, lat, busy_n, l, g, e);
            chk($sformatf("sb_w%0d_%0d_res a=%0h b=%0h", w, n, av, bv), {l, g, e}, exp_r);
            chk($sformatf("sb_w%0d_%0d_lat", w, n), lat, exp_lat(w, av, bv));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
